l2_req_responder: RTL and testbench



---
 rtl/spandex_home_pkg.sv | 58 +++++
 rtl/l2_req_responder.sv | 119 +++++++++++
 tb/tb_l2_req_responder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spandex_home_pkg.sv
// Shared types for the Spandex home-side request responder.
// Holds message codes, FSM states and the latched request bundle.
package spandex_home_pkg;

    localparam int LINE_WORDS = 4;
    localparam int WORD_BITS  = 64;
    localparam int ADDR_BITS  = 28;
    localparam int CNT_BITS   = 4;
    localparam int LINE_BITS  = LINE_WORDS * WORD_BITS;

    localparam logic [2:0] REQ_V     = 3'd0;
    localparam logic [2:0] REQ_S     = 3'd1;
    localparam logic [2:0] REQ_WT    = 3'd2;
    localparam logic [2:0] REQ_O     = 3'd3;
    localparam logic [2:0] REQ_WB    = 3'd4;
    localparam logic [2:0] REQ_ODATA = 3'd5;

    localparam logic [2:0] RSP_S      = 3'd0;
    localparam logic [2:0] RSP_O      = 3'd1;
    localparam logic [2:0] RSP_V      = 3'd2;
    localparam logic [2:0] RSP_WB_ACK = 3'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        RSP      = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0]           coh_msg;
        logic                 hprot;
        logic [ADDR_BITS-1:0] addr;
        logic [LINE_BITS-1:0] line;
        logic [LINE_WORDS-1:0] word_mask;
    } req_latch_t;

    function automatic logic is_read(input logic [2:0] m);
        return (m == REQ_V) || (m == REQ_S) || (m == REQ_ODATA);
    endfunction

    function automatic logic is_write(input logic [2:0] m);
        return (m == REQ_WT) || (m == REQ_WB);
    endfunction

    function automatic logic [2:0] rsp_msg(input logic [2:0] m);
        logic [2:0] r;
        r = RSP_WB_ACK;
        case (m)
            REQ_V:              r = RSP_V;
            REQ_S:              r = RSP_S;
            REQ_O, REQ_ODATA:   r = RSP_O;
            default:            r = RSP_WB_ACK;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/l2_req_responder.sv
// Directory-less home endpoint: services one L2 request at a time
// against a simple backing-memory port and returns the response.
module l2_req_responder
    import spandex_home_pkg::*;
#(
    parameter int WORDS_PER_LINE = LINE_WORDS,
    parameter int BITS_PER_WORD  = WORD_BITS,
    parameter int LINE_ADDR_BITS = ADDR_BITS,
    parameter int INVACK_BITS    = CNT_BITS
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    l2_req_out_valid,
    output logic                                    l2_req_out_ready,
    input  logic [2:0]                              l2_req_out_coh_msg,
    input  logic                                    l2_req_out_hprot,
    input  logic [LINE_ADDR_BITS-1:0]               l2_req_out_addr,
    input  logic [WORDS_PER_LINE*BITS_PER_WORD-1:0] l2_req_out_line,
    input  logic [WORDS_PER_LINE-1:0]               l2_req_out_word_mask,
    output logic                                    l2_rsp_in_valid,
    input  logic                                    l2_rsp_in_ready,
    output logic [2:0]                              l2_rsp_in_coh_msg,
    output logic [LINE_ADDR_BITS-1:0]               l2_rsp_in_addr,
    output logic [WORDS_PER_LINE*BITS_PER_WORD-1:0] l2_rsp_in_line,
    output logic [WORDS_PER_LINE-1:0]               l2_rsp_in_word_mask,
    output logic [INVACK_BITS-1:0]                  l2_rsp_in_invack_cnt,
    output logic                                    mem_req_valid,
    input  logic                                    mem_req_ready,
    output logic                                    mem_req_write,
    output logic                                    mem_req_hprot,
    output logic [LINE_ADDR_BITS-1:0]               mem_req_addr,
    output logic [WORDS_PER_LINE*BITS_PER_WORD-1:0] mem_req_line,
    output logic [WORDS_PER_LINE-1:0]               mem_req_wmask,
    input  logic                                    mem_rsp_valid,
    input  logic [WORDS_PER_LINE*BITS_PER_WORD-1:0] mem_rsp_line,
    output logic                                    bad_msg_err
);

    state_t     state, state_nxt;
    req_latch_t req;
    logic [WORDS_PER_LINE*BITS_PER_WORD-1:0] rd_line;
    logic accept;
    logic in_msg_ok;
    logic rsp_has_data;

    assign l2_req_out_ready = rst && (state == IDLE);
    assign accept    = l2_req_out_valid && l2_req_out_ready;
    assign in_msg_ok = is_read(l2_req_out_coh_msg)
                    || is_write(l2_req_out_coh_msg)
                    || (l2_req_out_coh_msg == REQ_O);

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            (state == IDLE): begin
                if (accept) begin
                    if (is_read(l2_req_out_coh_msg) || is_write(l2_req_out_coh_msg))
                        state_nxt = MEM_REQ;
                    else if (l2_req_out_coh_msg == REQ_O)
                        state_nxt = RSP;
                end
            end
            (state == MEM_REQ): begin
                if (mem_req_ready)
                    state_nxt = is_write(req.coh_msg) ? RSP : MEM_WAIT;
            end
            (state == MEM_WAIT): begin
                if (mem_rsp_valid)
                    state_nxt = RSP;
            end
            (state == RSP): begin
                if (l2_rsp_in_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            req         <= '0;
            rd_line     <= '0;
            bad_msg_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req.coh_msg   <= l2_req_out_coh_msg;
                req.hprot     <= l2_req_out_hprot;
                req.addr      <= l2_req_out_addr;
                req.line      <= l2_req_out_line;
                req.word_mask <= l2_req_out_word_mask;
            end
            if ((state == MEM_WAIT) && mem_rsp_valid)
                rd_line <= mem_rsp_line;
            if (accept && !in_msg_ok)
                bad_msg_err <= 1'b1;
        end
    end

    // Outputs are forced to zero whenever their valid is low.
    assign mem_req_valid = (state == MEM_REQ);
    assign mem_req_write = mem_req_valid && is_write(req.coh_msg);
    assign mem_req_hprot = mem_req_valid && req.hprot;
    assign mem_req_addr  = mem_req_valid ? req.addr : '0;
    assign mem_req_line  = mem_req_write ? req.line : '0;
    assign mem_req_wmask = mem_req_write ? req.word_mask : '0;

    assign rsp_has_data = is_read(req.coh_msg);

    assign l2_rsp_in_valid     = (state == RSP);
    assign l2_rsp_in_coh_msg   = l2_rsp_in_valid ? rsp_msg(req.coh_msg) : '0;
    assign l2_rsp_in_addr      = l2_rsp_in_valid ? req.addr : '0;
    assign l2_rsp_in_line      = (l2_rsp_in_valid && rsp_has_data) ? rd_line : '0;
    assign l2_rsp_in_word_mask = !l2_rsp_in_valid ? '0
                               : (req.coh_msg == REQ_S) ? '1 : req.word_mask;
    assign l2_rsp_in_invack_cnt = '0;

endmodule

// File: tb/tb_l2_req_responder.sv
// Randomized lockstep bench for l2_req_responder with a memory
// model and expected responses derived from the message rules.
module tb_l2_req_responder;
    import spandex_home_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         l2_req_out_valid;
    logic         l2_req_out_ready;
    logic [2:0]   l2_req_out_coh_msg;
    logic         l2_req_out_hprot;
    logic [27:0]  l2_req_out_addr;
    logic [255:0] l2_req_out_line;
    logic [3:0]   l2_req_out_word_mask;
    logic         l2_rsp_in_valid;
    logic         l2_rsp_in_ready;
    logic [2:0]   l2_rsp_in_coh_msg;
    logic [27:0]  l2_rsp_in_addr;
    logic [255:0] l2_rsp_in_line;
    logic [3:0]   l2_rsp_in_word_mask;
    logic [3:0]   l2_rsp_in_invack_cnt;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_write;
    logic         mem_req_hprot;
    logic [27:0]  mem_req_addr;
    logic [255:0] mem_req_line;
    logic [3:0]   mem_req_wmask;
    logic         mem_rsp_valid;
    logic [255:0] mem_rsp_line;
    logic         bad_msg_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic bad_seen = 1'b0;
    logic [255:0] mem [logic [27:0]];

    always #5 clk = ~clk;

    l2_req_responder dut (
        .clk(clk), .rst(rst),
        .l2_req_out_valid(l2_req_out_valid),
        .l2_req_out_ready(l2_req_out_ready),
        .l2_req_out_coh_msg(l2_req_out_coh_msg),
        .l2_req_out_hprot(l2_req_out_hprot),
        .l2_req_out_addr(l2_req_out_addr),
        .l2_req_out_line(l2_req_out_line),
        .l2_req_out_word_mask(l2_req_out_word_mask),
        .l2_rsp_in_valid(l2_rsp_in_valid),
        .l2_rsp_in_ready(l2_rsp_in_ready),
        .l2_rsp_in_coh_msg(l2_rsp_in_coh_msg),
        .l2_rsp_in_addr(l2_rsp_in_addr),
        .l2_rsp_in_line(l2_rsp_in_line),
        .l2_rsp_in_word_mask(l2_rsp_in_word_mask),
        .l2_rsp_in_invack_cnt(l2_rsp_in_invack_cnt),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write),
        .mem_req_hprot(mem_req_hprot),
        .mem_req_addr(mem_req_addr),
        .mem_req_line(mem_req_line),
        .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_line(mem_rsp_line),
        .bad_msg_err(bad_msg_err)
    );

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [255:0] mem_rd(input logic [27:0] a);
        if (mem.exists(a)) return mem[a];
        return {8{4'h5, a}};
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mreq"}, {mem_req_valid, mem_req_write, mem_req_hprot,
              mem_req_addr, mem_req_wmask}, '0);
        check({tag, "_mline"}, mem_req_line, '0);
        check({tag, "_rsp"}, {l2_rsp_in_valid, l2_rsp_in_coh_msg,
              l2_rsp_in_addr, l2_rsp_in_word_mask, l2_rsp_in_invack_cnt}, '0);
        check({tag, "_rline"}, l2_rsp_in_line, '0);
    endtask

    task automatic run_req(input logic [2:0] m, input logic hp,
                           input logic [27:0] a, input logic [255:0] d,
                           input logic [3:0] k, input int mrd,
                           input int lat, input int srd);
        logic rd, wr;
        logic [255:0] rl, el;
        logic [2:0] em;
        logic [3:0] ek;
        rd = (m == REQ_V) || (m == REQ_S) || (m == REQ_ODATA);
        wr = (m == REQ_WT) || (m == REQ_WB);
        rl = '0;
        check("req_rdy_idle", l2_req_out_ready, 1'b1);
        l2_req_out_valid     = 1'b1;
        l2_req_out_coh_msg   = m;
        l2_req_out_hprot     = hp;
        l2_req_out_addr      = a;
        l2_req_out_line      = d;
        l2_req_out_word_mask = k;
        tick();
        l2_req_out_valid     = 1'b0;
        l2_req_out_coh_msg   = 3'($urandom());
        l2_req_out_hprot     = 1'($urandom());
        l2_req_out_addr      = 28'($urandom());
        l2_req_out_line      = rnd_line();
        l2_req_out_word_mask = 4'($urandom());
        if (!rd && !wr && m != REQ_O) begin
            bad_seen = 1'b1;
            check("bad_err_set", bad_msg_err, 1'b1);
            check("bad_no_mreq", mem_req_valid, 1'b0);
            check("bad_no_rsp", l2_rsp_in_valid, 1'b0);
            check("bad_rdy", l2_req_out_ready, 1'b1);
            tick();
            check("bad_no_mreq2", mem_req_valid, 1'b0);
            check("bad_no_rsp2", l2_rsp_in_valid, 1'b0);
            return;
        end
        check("req_rdy_busy", l2_req_out_ready, 1'b0);
        if (rd || wr) begin
            for (int c = 0; c <= mrd; c++) begin
                check("mreq_valid", mem_req_valid, 1'b1);
                check("mreq_write", mem_req_write, wr);
                check("mreq_hprot", mem_req_hprot, hp);
                check("mreq_addr", mem_req_addr, a);
                if (wr) begin
                    check("mreq_wmask", mem_req_wmask, k);
                    check("mreq_line", mem_req_line, d);
                end
                check("mreq_no_rsp", l2_rsp_in_valid, 1'b0);
                check("mreq_rdy", l2_req_out_ready, 1'b0);
                mem_req_ready = (c == mrd);
                mem_rsp_valid = (c != mrd) && ($urandom_range(0, 1) == 1);
                mem_rsp_line  = rnd_line();
                tick();
            end
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            if (wr) begin
                logic [255:0] cur;
                cur = mem_rd(a);
                for (int w = 0; w < 4; w++)
                    if (k[w]) cur[w*64 +: 64] = d[w*64 +: 64];
                mem[a] = cur;
            end
            if (rd) begin
                rl = mem_rd(a);
                for (int c = 1; c < lat; c++) begin
                    check("wait_no_mreq", mem_req_valid, 1'b0);
                    check("wait_no_rsp", l2_rsp_in_valid, 1'b0);
                    tick();
                end
                mem_rsp_valid = 1'b1;
                mem_rsp_line  = rl;
                tick();
                mem_rsp_valid = 1'b0;
                mem_rsp_line  = rnd_line();
            end
        end
        em = (m == REQ_V) ? RSP_V : (m == REQ_S) ? RSP_S
           : (m == REQ_O || m == REQ_ODATA) ? RSP_O : RSP_WB_ACK;
        el = rd ? rl : '0;
        ek = (m == REQ_S) ? 4'hF : k;
        for (int c = 0; c <= srd; c++) begin
            check("rsp_valid", l2_rsp_in_valid, 1'b1);
            check("rsp_msg", l2_rsp_in_coh_msg, em);
            check("rsp_addr", l2_rsp_in_addr, a);
            check("rsp_line", l2_rsp_in_line, el);
            check("rsp_mask", l2_rsp_in_word_mask, ek);
            check("rsp_invack", l2_rsp_in_invack_cnt, 4'd0);
            check("rsp_no_mreq", mem_req_valid, 1'b0);
            check("rsp_req_rdy", l2_req_out_ready, 1'b0);
            l2_rsp_in_ready = (c == srd);
            tick();
        end
        l2_rsp_in_ready = 1'b0;
        check("post_rsp_valid", l2_rsp_in_valid, 1'b0);
        check("post_req_rdy", l2_req_out_ready, 1'b1);
        check("bad_err_sticky", bad_msg_err, bad_seen);
    endtask

    initial begin
        rst = 1'b0;
        l2_req_out_valid = 1'b0;
        l2_req_out_coh_msg = '0;
        l2_req_out_hprot = 1'b0;
        l2_req_out_addr = '0;
        l2_req_out_line = '0;
        l2_req_out_word_mask = '0;
        l2_rsp_in_ready = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_line = '0;
        tick();
        tick();
        check("rst_req_rdy", l2_req_out_ready, 1'b0);
        check("rst_bad_err", bad_msg_err, 1'b0);
        check_idle_outputs("rst");
        rst = 1'b1;
        tick();

        run_req(REQ_V, 1'b1, 28'h123, rnd_line(), 4'b0011, 0, 3, 0);
        run_req(REQ_WB, 1'b0, 28'h40, rnd_line(), 4'b1010, 0, 1, 0);
        run_req(REQ_V, 1'b0, 28'h40, rnd_line(), 4'b1111, 0, 1, 0);
        run_req(REQ_O, 1'b0, 28'h77, rnd_line(), 4'b1111, 0, 1, 4);
        run_req(REQ_S, 1'b1, 28'h123, rnd_line(), 4'b0001, 3, 2, 0);
        run_req(REQ_WT, 1'b1, 28'h40, rnd_line(), 4'b0000, 1, 1, 1);
        run_req(3'd7, 1'b0, 28'h55, rnd_line(), 4'b0101, 0, 1, 0);
        run_req(REQ_V, 1'b0, 28'h55, rnd_line(), 4'b0101, 0, 1, 0);
        run_req(REQ_ODATA, 1'b0, 28'h123, rnd_line(), 4'b0110, 2, 4, 2);

        for (int i = 0; i < 120; i++) begin
            logic [2:0] m;
            logic [27:0] a;
            m = 3'($urandom_range(0, 7));
            a = 28'h100 + 28'($urandom_range(0, 7));
            run_req(m, 1'($urandom()), a, rnd_line(), 4'($urandom()),
                    $urandom_range(0, 3), $urandom_range(1, 4),
                    $urandom_range(0, 3));
        end

        // Reset while a read waits on memory, then a late memory reply.
        l2_req_out_valid   = 1'b1;
        l2_req_out_coh_msg = REQ_V;
        l2_req_out_addr    = 28'h9AB;
        l2_req_out_word_mask = 4'hF;
        tick();
        l2_req_out_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        bad_seen = 1'b0;
        check("mid_rst_req_rdy", l2_req_out_ready, 1'b0);
        check("mid_rst_bad_err", bad_msg_err, 1'b0);
        check_idle_outputs("mid_rst");
        rst = 1'b1;
        #1;
        check("post_rst_rdy", l2_req_out_ready, 1'b1);
        mem_rsp_valid = 1'b1;
        mem_rsp_line  = rnd_line();
        tick();
        mem_rsp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("late_rsp_ignored", l2_rsp_in_valid, 1'b0);
            check("late_no_mreq", mem_req_valid, 1'b0);
            check("late_rdy", l2_req_out_ready, 1'b1);
            tick();
        end
        run_req(REQ_S, 1'b0, 28'h9AB, rnd_line(), 4'b0010, 0, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
